// File: rtl/seq_divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;
  localparam int CNT_W  = $clog2(DW_DEF);

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module seq_divider_step
  import seq_divider_pkg::*;
#(
  parameter int VW = VW_DEF
) (
  input  logic [VW:0]   r,
  input  logic          q_msb,
  input  logic [VW-1:0] d,
  output logic [VW:0]   r_next,
  output logic          q_bit
);

  logic [VW:0] t;
  logic [VW:0] d_ext;

  // The partial remainder is always below the divisor, so its top bit is zero here.
  logic unused_r_msb;
  assign unused_r_msb = r[VW];

  assign t     = {r[VW-1:0], q_msb};
  assign d_ext = {1'b0, d};

  always_comb begin
    r_next = t;
    q_bit  = 1'b0;
    if (t >= d_ext) begin
      r_next = t - d_ext;
      q_bit  = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, with registered results.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  state_t        state;
  logic [DW-1:0] q;
  logic [VW:0]   r;
  logic [VW-1:0] d;
  logic [CW-1:0] cnt;

  logic [VW:0]   r_next;
  logic          q_bit;
  logic [DW-1:0] q_next;

  seq_divider_step #(.VW(VW)) u_step (
    .r      (r),
    .q_msb  (q[DW-1]),
    .d      (d),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  assign q_next = {q[DW-2:0], q_bit};

  // Results are loaded on the edge that enters DONE so they are valid alongside the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      q           <= '0;
      r           <= '0;
      d           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor != '0) begin
              q     <= dividend;
              r     <= '0;
              d     <= divisor;
              cnt   <= CW'(DW - 1);
              busy  <= 1'b1;
              state <= RUN;
            end else begin
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end
          end
        end
        RUN: begin
          q <= q_next;
          r <= r_next;
          if (cnt == '0) begin
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_next;
            remainder   <= r_next[VW-1:0];
            div_by_zero <= 1'b0;
            state       <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
